// File: rtl/pulse_stretcher_pkg.sv
// Shared types and 12 MHz timing defaults for the
// pulse stretcher and its users.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    WARMUP   = 2'd0,
    IDLE     = 2'd1,
    ACTIVE   = 2'd2,
    COOLDOWN = 2'd3
  } ps_state_e;

  localparam int CLK_HZ          = 12_000_000;
  localparam int DEF_HOLD_CYCLES = 12_000_000;
  localparam int DEF_COOL_CYCLES = 1_200_000;
  localparam int DEF_START_CYCLES = 65535;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher_counter.sv
// Loadable down-counter with zero flag, shared by
// every timed phase of the pulse stretcher.
module load_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (dec) begin
      q <= q - 1'b1;
    end
  end

  assign count = q;
  assign zero  = (q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches 1-cycle triggers into a fixed-width output
// level with startup inhibit, abort and cooldown.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOL_CYCLES,
  parameter int STARTUP_CYCLES  = DEF_START_CYCLES,
  parameter int RETRIGGER       = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_pulse,
  input  logic abort,
  output logic out_level,
  output logic busy,
  output logic armed,
  output logic dropped
);

  localparam int CW = cnt_width(
    HOLD_CYCLES, COOLDOWN_CYCLES, STARTUP_CYCLES);

  localparam bit HAS_COOL = (COOLDOWN_CYCLES > 0);
  localparam bit RETRIG   = (RETRIGGER != 0);

  localparam logic [CW-1:0] HOLD_M1 =
    CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] COOL_M1 =
    CW'(HAS_COOL ? COOLDOWN_CYCLES - 1 : 0);

  // Warmup decrements from 0 and wraps; after k edges
  // the count is -k, so the final warmup edge sees this.
  localparam logic [CW-1:0] WARM_END =
    CW'(0) - CW'(STARTUP_CYCLES - 1);

  ps_state_e     state;
  logic          ld;
  logic          dec;
  logic [CW-1:0] ld_val;
  logic [CW-1:0] cnt;
  logic          cnt_zero;

  load_down_counter #(
    .W(CW)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (ld_val),
    .dec      (dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    ld     = 1'b0;
    dec    = 1'b0;
    ld_val = '0;
    unique case (state)
      WARMUP: dec = 1'b1;
      IDLE: begin
        if (trig_pulse) begin
          ld     = 1'b1;
          ld_val = HOLD_M1;
        end
      end
      ACTIVE: begin
        if (abort) begin
          ld     = HAS_COOL;
          ld_val = COOL_M1;
        end else if (trig_pulse && RETRIG) begin
          ld     = 1'b1;
          ld_val = HOLD_M1;
        end else if (cnt_zero) begin
          ld     = HAS_COOL;
          ld_val = COOL_M1;
        end else begin
          dec = 1'b1;
        end
      end
      COOLDOWN: dec = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WARMUP;
      out_level <= 1'b0;
      busy      <= 1'b0;
      armed     <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      dropped <= 1'b0;
      unique case (state)
        WARMUP: begin
          if (cnt == WARM_END) begin
            state <= IDLE;
            armed <= 1'b1;
          end
        end
        IDLE: begin
          if (trig_pulse) begin
            state     <= ACTIVE;
            out_level <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ACTIVE: begin
          if (abort) begin
            out_level <= 1'b0;
            dropped   <= trig_pulse;
            busy      <= HAS_COOL;
            state     <= HAS_COOL ? COOLDOWN : IDLE;
          end else if (trig_pulse && RETRIG) begin
            out_level <= 1'b1;
          end else begin
            dropped <= trig_pulse;
            if (cnt_zero) begin
              out_level <= 1'b0;
              busy      <= HAS_COOL;
              state     <= HAS_COOL ? COOLDOWN : IDLE;
            end
          end
        end
        COOLDOWN: begin
          dropped <= trig_pulse;
          if (cnt_zero) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= WARMUP;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench: three configurations driven in parallel,
// checked each cycle against a time-window model.
module tb_pulse_stretcher;

  localparam int H = 5;
  localparam int S = 4;
  localparam int CC [3] = '{3, 3, 0};
  localparam int RR [3] = '{0, 1, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trig = 1'b0;
  logic abort = 1'b0;

  logic out_l [3];
  logic busy  [3];
  logic armed [3];
  logic drop  [3];

  int checks = 0;
  int errors = 0;

  int cnt_out  [3];
  int cnt_busy [3];
  int cnt_drop [3];

  // model: edge count and the edge indices where
  // the output window and the busy window end
  int k  [3];
  int he [3];
  int be [3];
  bit md [3];

  always #5 clk = ~clk;

  pulse_stretcher #(
    .HOLD_CYCLES(H), .COOLDOWN_CYCLES(3),
    .STARTUP_CYCLES(S), .RETRIGGER(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .trig_pulse(trig), .abort(abort),
    .out_level(out_l[0]), .busy(busy[0]),
    .armed(armed[0]), .dropped(drop[0])
  );

  pulse_stretcher #(
    .HOLD_CYCLES(H), .COOLDOWN_CYCLES(3),
    .STARTUP_CYCLES(S), .RETRIGGER(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .trig_pulse(trig), .abort(abort),
    .out_level(out_l[1]), .busy(busy[1]),
    .armed(armed[1]), .dropped(drop[1])
  );

  pulse_stretcher #(
    .HOLD_CYCLES(H), .COOLDOWN_CYCLES(0),
    .STARTUP_CYCLES(S), .RETRIGGER(0)
  ) dut_c (
    .clk(clk), .rst_n(rst_n),
    .trig_pulse(trig), .abort(abort),
    .out_level(out_l[2]), .busy(busy[2]),
    .armed(armed[2]), .dropped(drop[2])
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        k[i]  <= 0;
        he[i] <= 0;
        be[i] <= 0;
        md[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int kk;
        int nh;
        int nb;
        bit nd;
        kk = k[i] + 1;
        nh = he[i];
        nb = be[i];
        nd = 1'b0;
        if (k[i] >= S) begin
          if (k[i] >= be[i]) begin
            if (trig) begin
              nh = kk + H;
              nb = nh + CC[i];
            end
          end else if (k[i] < he[i]) begin
            if (abort) begin
              nh = kk;
              nb = kk + CC[i];
              nd = trig;
            end else if (trig) begin
              if (RR[i] != 0) begin
                nh = kk + H;
                nb = nh + CC[i];
              end else begin
                nd = 1'b1;
              end
            end
          end else begin
            nd = trig;
          end
        end
        k[i]  <= kk;
        he[i] <= nh;
        be[i] <= nb;
        md[i] <= nd;
      end
    end
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 3; i++) begin
      cnt_out[i]  = 0;
      cnt_busy[i] = 0;
      cnt_drop[i] = 0;
    end
  endtask

  task automatic cyc(input bit t, input bit a);
    trig  = t;
    abort = a;
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("out[%0d] t=%0t", i, $time),
          int'(out_l[i]), int'(k[i] < he[i]));
      chk($sformatf("busy[%0d] t=%0t", i, $time),
          int'(busy[i]), int'(k[i] < be[i]));
      chk($sformatf("armed[%0d] t=%0t", i, $time),
          int'(armed[i]), int'(k[i] >= S));
      chk($sformatf("drop[%0d] t=%0t", i, $time),
          int'(drop[i]), int'(md[i]));
      cnt_out[i]  += int'(out_l[i]);
      cnt_busy[i] += int'(busy[i]);
      cnt_drop[i] += int'(drop[i]);
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(1'b0, 1'b0);
  endtask

  initial begin
    clr_counts();
    idle(2);
    chk("reset armed", int'(armed[0]), 0);
    chk("reset out", int'(out_l[0]), 0);
    rst_n = 1'b1;

    // startup: triggers ignored until armed
    clr_counts();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("warm armed e3", int'(armed[0]), 0);
    cyc(1'b0, 1'b0);
    chk("warm armed e4", int'(armed[0]), 1);
    chk("warm out", cnt_out[0], 0);
    chk("warm drop", cnt_drop[0] + cnt_drop[1], 0);

    // basic window
    clr_counts();
    cyc(1'b1, 1'b0);
    idle(12);
    chk("basic out a", cnt_out[0], 5);
    chk("basic busy a", cnt_busy[0], 8);
    chk("basic busy c", cnt_busy[2], 5);

    // drop vs retrigger
    clr_counts();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    idle(13);
    chk("drop out a", cnt_out[0], 5);
    chk("drop cnt a", cnt_drop[0], 1);
    chk("retrig out b", cnt_out[1], 7);
    chk("retrig drop b", cnt_drop[1], 0);
    chk("retrig busy b", cnt_busy[1], 10);

    // abort
    clr_counts();
    cyc(1'b1, 1'b0);
    idle(2);
    cyc(1'b0, 1'b1);
    idle(10);
    chk("abort out a", cnt_out[0], 3);
    chk("abort busy a", cnt_busy[0], 6);
    chk("abort busy c", cnt_busy[2], 3);

    // abort and trigger together
    clr_counts();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    idle(10);
    chk("abtrig drop a", cnt_drop[0], 1);
    chk("abtrig drop b", cnt_drop[1], 1);
    chk("abtrig out b", cnt_out[1], 2);

    // trigger in cooldown / zero cooldown
    clr_counts();
    cyc(1'b1, 1'b0);
    idle(5);
    cyc(1'b1, 1'b0);
    idle(12);
    chk("cool out a", cnt_out[0], 5);
    chk("cool drop a", cnt_drop[0], 1);
    chk("nocool out c", cnt_out[2], 10);
    chk("nocool drop c", cnt_drop[2], 0);

    // async reset mid-window
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("pre-rst out", int'(out_l[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst out[%0d]", i),
          int'(out_l[i]), 0);
      chk($sformatf("arst busy[%0d]", i),
          int'(busy[i]), 0);
      chk($sformatf("arst armed[%0d]", i),
          int'(armed[i]), 0);
    end
    idle(2);
    rst_n = 1'b1;
    idle(3);
    chk("rewarm armed e3", int'(armed[1]), 0);
    cyc(1'b0, 1'b0);
    chk("rewarm armed e4", int'(armed[1]), 1);
    cyc(1'b1, 1'b0);
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
